// File: rtl/sr_latch_driver.sv
// sr_latch_driver: pulse driver for a downstream NAND SR latch.
//
// Two level requests (set_req, clr_req) are debounced independently; each
// rising edge of a debounced level becomes a one-cycle event. An FSM turns
// events into active-low pulses on s_n / r_n of PULSE_CYCLES cycles, each
// followed by GAP_CYCLES cycles with both drives high. One pending slot holds
// the most recent event seen while busy. On leaving reset the block issues
// an initial clear pulse so the latch agrees with q_est = 0.
//
// Parameters
//   DEB_CYCLES   : consecutive differing samples before a level is accepted (1..255)
//   PULSE_CYCLES : low time of each s_n / r_n pulse (1..15)
//   GAP_CYCLES   : both-high time after each pulse (1..15)
//
// Ports
//   clk          : clock, all state on the rising edge
//   rst          : synchronous active-high reset
//   set_req      : set request level
//   clr_req      : clear request level
//   s_n          : active-low set drive (registered)
//   r_n          : active-low reset drive (registered)
//   busy         : high whenever the FSM is not idle (registered)
//   q_est        : expected latch Q after the last completed pulse (registered)
//   conflict_cnt : [7:0] saturating count of dropped or overwritten events,
//                  present only when SR_DRV_CONFLICT_CNT_EN is defined
//
// Build option
//   SR_DRV_CONFLICT_CNT_EN : adds the conflict_cnt output and its counter.

module sr_latch_driver #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s_n,
  output logic       r_n,
  output logic       busy,
  output logic       q_est
`ifdef SR_DRV_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  localparam logic [7:0] DebLast   = 8'(DEB_CYCLES - 1);
  localparam logic [3:0] PulseLast = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GapLast   = 4'(GAP_CYCLES - 1);

  // Index 0 = set request, index 1 = clear request.
  localparam int unsigned IdxSet = 0;
  localparam int unsigned IdxClr = 1;

  typedef enum logic [1:0] {
    StIdle,
    StSetP,
    StClrP,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [1:0] req;
  logic [1:0] stable_q, stable_d;
  logic [7:0] deb_cnt_q [2];
  logic [7:0] deb_cnt_d [2];
  logic [1:0] rise;
  logic [1:0] ev_q;

  assign req = {clr_req, set_req};

  always_comb begin
    stable_d = stable_q;
    rise     = '0;
    for (int i = 0; i < 2; i++) begin
      // Any sample equal to the stable level restarts the count.
      deb_cnt_d[i] = '0;
      if (req[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          stable_d[i] = req[i];
          rise[i]     = req[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event arbitration
  // ---------------------------------------------------------------------------
  logic ev_any;
  logic ev_is_clr;
  logic sim_drop;
  logic ovw;
  logic eff_vld;
  logic eff_clr;

  logic pend_vld_q, pend_vld_d;
  logic pend_clr_q, pend_clr_d;

  // Simultaneous events resolve to clear; the set is dropped.
  assign ev_any    = ev_q[IdxSet] | ev_q[IdxClr];
  assign ev_is_clr = ev_q[IdxClr];
  assign sim_drop  = ev_q[IdxSet] & ev_q[IdxClr];

  // A fresh event replaces whatever the pending slot holds (last wins).
  assign ovw     = ev_any & pend_vld_q;
  assign eff_vld = ev_any | pend_vld_q;
  assign eff_clr = ev_any ? ev_is_clr : pend_clr_q;

  // ---------------------------------------------------------------------------
  // Pulse FSM
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       init_q;
  logic       q_est_q, q_est_d;
  logic       s_n_q, r_n_q, busy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_clr_d = pend_clr_q;
    q_est_d    = q_est_q;

    unique case (state_q)
      StIdle: begin
        if (init_q) begin
          // First edge out of reset: force the latch to match q_est = 0.
          state_d    = StClrP;
          cnt_d      = '0;
          pend_vld_d = eff_vld;
          pend_clr_d = eff_clr;
        end else if (eff_vld) begin
          state_d    = eff_clr ? StClrP : StSetP;
          cnt_d      = '0;
          pend_vld_d = 1'b0;
        end
      end

      StSetP, StClrP: begin
        pend_vld_d = eff_vld;
        pend_clr_d = eff_clr;
        if (cnt_q == PulseLast) begin
          state_d = StGap;
          cnt_d   = '0;
          q_est_d = (state_q == StSetP);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          if (eff_vld) begin
            state_d = eff_clr ? StClrP : StSetP;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d      = cnt_q + 4'd1;
          pend_vld_d = eff_vld;
          pend_clr_d = eff_clr;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q     <= '0;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      ev_q         <= '0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      pend_vld_q   <= 1'b0;
      pend_clr_q   <= 1'b0;
      init_q       <= 1'b1;
      q_est_q      <= 1'b0;
      s_n_q        <= 1'b1;
      r_n_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      stable_q     <= stable_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      ev_q         <= rise;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_vld_q   <= pend_vld_d;
      pend_clr_q   <= pend_clr_d;
      init_q       <= 1'b0;
      q_est_q      <= q_est_d;
      // Drives follow the next state so they are registered yet aligned
      // with the state; SET_P and CLR_P are exclusive, so the drives are too.
      s_n_q        <= (state_d != StSetP);
      r_n_q        <= (state_d != StClrP);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign s_n   = s_n_q;
  assign r_n   = r_n_q;
  assign busy  = busy_q;
  assign q_est = q_est_q;

`ifdef SR_DRV_CONFLICT_CNT_EN
  // ---------------------------------------------------------------------------
  // Conflict counter: a drop and an overwrite in one cycle count twice.
  // ---------------------------------------------------------------------------
  logic [7:0] conflict_q, conflict_d;
  logic [8:0] conflict_sum;

  always_comb begin
    conflict_sum = {1'b0, conflict_q} + {8'd0, sim_drop} + {8'd0, ovw};
    conflict_d   = conflict_sum[8] ? 8'hff : conflict_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  logic unused_conflict;
  assign unused_conflict = sim_drop ^ ovw;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with default parameters.
// Each cycle the expected {s_n, r_n, busy, q_est} is queued as the inputs
// are driven and popped for comparison one time unit after the clock edge.

module tb_sr_latch_driver;

  localparam int unsigned PulseCycles = 2;
  localparam int unsigned GapCycles   = 1;

  logic clk;
  logic rst;
  logic set_req;
  logic clr_req;
  logic s_n;
  logic r_n;
  logic busy;
  logic q_est;
`ifdef SR_DRV_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] sb [$];

  // {s_n, r_n, busy, q_est}
  localparam logic [3:0] IdleQ0 = 4'b1100;
  localparam logic [3:0] IdleQ1 = 4'b1101;

  sr_latch_driver #(
    .DEB_CYCLES  (4),
    .PULSE_CYCLES(PulseCycles),
    .GAP_CYCLES  (GapCycles)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .set_req(set_req),
    .clr_req(clr_req),
    .s_n    (s_n),
    .r_n    (r_n),
    .busy   (busy),
    .q_est  (q_est)
`ifdef SR_DRV_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: queue the expectation, step the edge, compare outputs.
  task automatic cyc(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    logic [3:0] want;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    got  = {s_n, r_n, busy, q_est};
    want = sb.pop_front();
    check_eq(tag, {4'd0, got}, {4'd0, want});
    check_eq({tag, "_nand_safe"}, {7'd0, s_n | r_n}, 8'd1);
  endtask

  task automatic idle_for(input string tag, input int n, input logic [3:0] exp);
    for (int i = 0; i < n; i++) cyc(tag, exp);
  endtask

  // Full pulse plus gap; q_est takes its new value as the gap starts.
  task automatic pulse(input string tag, input logic is_set, input logic q_old);
    logic [3:0] p;
    p = is_set ? {1'b0, 1'b1, 1'b1, q_old} : {1'b1, 1'b0, 1'b1, q_old};
    for (int i = 0; i < PulseCycles; i++) cyc({tag, "_pulse"}, p);
    for (int i = 0; i < GapCycles; i++) cyc({tag, "_gap"}, {3'b111, is_set});
  endtask

  initial begin
    rst     = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;

    // Reset for 3 cycles, then the init clear pulse.
    idle_for("reset", 3, IdleQ0);
`ifdef SR_DRV_CONFLICT_CNT_EN
    check_eq("conflict_reset", conflict_cnt, 8'd0);
`endif
    rst = 1'b0;
    pulse("init", 1'b0, 1'b0);
    idle_for("post_init", 3, IdleQ0);

    // Set held 10 cycles: s_n low on edges 5-6, one pulse only.
    set_req = 1'b1;
    idle_for("set_deb", 4, IdleQ0);
    pulse("set", 1'b1, 1'b0);
    idle_for("set_hold", 3, IdleQ1);
    set_req = 1'b0;
    idle_for("set_release", 6, IdleQ1);

    // Repeat set while q_est is already 1: still a full pulse.
    set_req = 1'b1;
    idle_for("reset_deb", 4, IdleQ1);
    pulse("set_repeat", 1'b1, 1'b1);
    set_req = 1'b0;
    idle_for("repeat_release", 6, IdleQ1);

    // 3-cycle glitch is shorter than the debounce window.
    set_req = 1'b1;
    idle_for("glitch_hi", 3, IdleQ1);
    set_req = 1'b0;
    idle_for("glitch_lo", 6, IdleQ1);

    // Simultaneous rise: clear wins, set dropped.
`ifdef SR_DRV_CONFLICT_CNT_EN
    check_eq("conflict_before_sim", conflict_cnt, 8'd0);
`endif
    set_req = 1'b1;
    clr_req = 1'b1;
    idle_for("sim_deb", 4, IdleQ1);
    pulse("sim_clr", 1'b0, 1'b1);
    set_req = 1'b0;
    clr_req = 1'b0;
    idle_for("sim_release", 6, IdleQ0);
`ifdef SR_DRV_CONFLICT_CNT_EN
    check_eq("conflict_after_sim", conflict_cnt, 8'd1);
`endif

    // Clear event arrives during the set pulse: pending, then clear pulse.
    set_req = 1'b1;
    cyc("pend_deb", IdleQ0);
    clr_req = 1'b1;
    idle_for("pend_deb", 3, IdleQ0);
    pulse("pend_set", 1'b1, 1'b0);
    pulse("pend_clr", 1'b0, 1'b1);
    set_req = 1'b0;
    clr_req = 1'b0;
    idle_for("pend_release", 6, IdleQ0);
`ifdef SR_DRV_CONFLICT_CNT_EN
    check_eq("conflict_after_pend", conflict_cnt, 8'd1);
`endif

    // Reset in the second cycle of SET_P: pulse discarded, then init clear.
    set_req = 1'b1;
    idle_for("rstmid_deb", 4, IdleQ0);
    cyc("rstmid_setp", 4'b0110);
    rst     = 1'b1;
    set_req = 1'b0;
    idle_for("rstmid_rst", 2, IdleQ0);
`ifdef SR_DRV_CONFLICT_CNT_EN
    check_eq("conflict_rstmid", conflict_cnt, 8'd0);
`endif
    rst = 1'b0;
    pulse("rstmid_init", 1'b0, 1'b0);
    idle_for("rstmid_idle", 3, IdleQ0);

    check_eq("sb_drained", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
